// File: rtl/tile_result_serializer.sv
// Drain stage for the tile array: captures a full result block plus its
// address and streams it out one word per cycle. An active slot drains while
// a pending slot holds the next block, so consecutive blocks leave with no bubble.
module tile_result_serializer #(
  parameter int unsigned BLOCK_BITS = 3,
  parameter int unsigned ADDR_BITS  = 6,
  parameter int unsigned WORD_BITS  = 16,
  localparam int unsigned TILES     = 1 << (2 * BLOCK_BITS),
  localparam int unsigned IDX_BITS  = 2 * BLOCK_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORD_BITS*TILES-1:0] in_block,
  input  logic [ADDR_BITS-1:0]       in_addr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD_BITS-1:0]       out_data,
  output logic [IDX_BITS-1:0]        out_index,
  output logic [ADDR_BITS-1:0]       out_addr,
  output logic                       out_last,
  output logic                       busy
);

  logic [WORD_BITS*TILES-1:0] a_block_q, a_block_d;
  logic [ADDR_BITS-1:0]       a_addr_q, a_addr_d;
  logic [IDX_BITS-1:0]        idx_q, idx_d;
  logic                       a_valid_q, a_valid_d;
  logic [WORD_BITS*TILES-1:0] p_block_q, p_block_d;
  logic [ADDR_BITS-1:0]       p_addr_q, p_addr_d;
  logic                       p_valid_q, p_valid_d;

  logic in_hs, out_hs, at_last;

  assign in_ready = ~p_valid_q;
  assign in_hs    = in_valid & in_ready;
  assign out_hs   = a_valid_q & out_ready;
  assign at_last  = (idx_q == IDX_BITS'(TILES - 1));

  assign out_valid = a_valid_q;
  assign out_data  = a_block_q[WORD_BITS * 32'(idx_q) +: WORD_BITS];
  assign out_index = idx_q;
  assign out_addr  = a_addr_q;
  assign out_last  = a_valid_q & at_last;
  assign busy      = a_valid_q | p_valid_q;

  // Slot bookkeeping: advance the index on accepts, hand P to A on the last
  // word, and route incoming blocks to whichever slot is free.
  always_comb begin
    a_block_d = a_block_q;
    a_addr_d  = a_addr_q;
    idx_d     = idx_q;
    a_valid_d = a_valid_q;
    p_block_d = p_block_q;
    p_addr_d  = p_addr_q;
    p_valid_d = p_valid_q;

    if (out_hs && at_last) begin
      idx_d = '0;
      if (p_valid_q) begin
        // in_ready is low here, so no input can race the handoff
        a_block_d = p_block_q;
        a_addr_d  = p_addr_q;
        p_valid_d = 1'b0;
      end else if (in_hs) begin
        a_block_d = in_block;
        a_addr_d  = in_addr;
      end else begin
        a_valid_d = 1'b0;
      end
    end else begin
      if (out_hs) begin
        idx_d = idx_q + 1'b1;
      end
      if (in_hs) begin
        if (!a_valid_q) begin
          a_block_d = in_block;
          a_addr_d  = in_addr;
          a_valid_d = 1'b1;
          idx_d     = '0;
        end else begin
          p_block_d = in_block;
          p_addr_d  = in_addr;
          p_valid_d = 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_block_q <= '0;
      a_addr_q  <= '0;
      idx_q     <= '0;
      a_valid_q <= 1'b0;
      p_block_q <= '0;
      p_addr_q  <= '0;
      p_valid_q <= 1'b0;
    end else begin
      a_block_q <= a_block_d;
      a_addr_q  <= a_addr_d;
      idx_q     <= idx_d;
      a_valid_q <= a_valid_d;
      p_block_q <= p_block_d;
      p_addr_q  <= p_addr_d;
      p_valid_q <= p_valid_d;
    end
  end

endmodule

// File: tb/tb_tile_result_serializer.sv
// Scoreboard bench for tile_result_serializer: every accepted block pushes its
// 64 expected words; every accepted output word pops and compares one.
module tb_tile_result_serializer;

  localparam int unsigned BLOCK_BITS = 3;
  localparam int unsigned ADDR_BITS  = 6;
  localparam int unsigned WORD_BITS  = 16;
  localparam int unsigned TILES      = 64;
  localparam int unsigned IDX_BITS   = 6;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [IDX_BITS-1:0]  idx;
    logic [WORD_BITS-1:0] data;
  } exp_t;

  logic                       clk;
  logic                       rst;
  logic                       in_valid;
  logic                       in_ready;
  logic [WORD_BITS*TILES-1:0] in_block;
  logic [ADDR_BITS-1:0]       in_addr;
  logic                       out_valid;
  logic                       out_ready;
  logic [WORD_BITS-1:0]       out_data;
  logic [IDX_BITS-1:0]        out_index;
  logic [ADDR_BITS-1:0]       out_addr;
  logic                       out_last;
  logic                       busy;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_words  = 0;
  int   cyc      = 0;
  int   hs_first = 0;
  int   hs_last  = 0;
  logic bp_mode  = 1'b0;
  logic prev_stall = 1'b0;
  logic [WORD_BITS-1:0] prev_data;
  logic [IDX_BITS-1:0]  prev_idx;

  tile_result_serializer #(
    .BLOCK_BITS(BLOCK_BITS),
    .ADDR_BITS (ADDR_BITS),
    .WORD_BITS (WORD_BITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_block (in_block),
    .in_addr  (in_addr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_addr (out_addr),
    .out_last (out_last),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d",
             n_checks, n_errors);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WORD_BITS*TILES-1:0] make_block(input logic [WORD_BITS-1:0] base);
    logic [WORD_BITS*TILES-1:0] b;
    for (int i = 0; i < TILES; i++) b[WORD_BITS*i +: WORD_BITS] = base + WORD_BITS'(i);
    return b;
  endfunction

  // Monitor on the falling edge: record accepted blocks, score accepted words.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (in_valid && in_ready) begin
        for (int i = 0; i < TILES; i++) begin
          exp_t e;
          e.addr = in_addr;
          e.idx  = IDX_BITS'(i);
          e.data = in_block[WORD_BITS*i +: WORD_BITS];
          sb.push_back(e);
        end
      end
      if (prev_stall && out_valid) begin
        check_eq("stall_data", 32'(out_data), 32'(prev_data));
        check_eq("stall_index", 32'(out_index), 32'(prev_idx));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("out_data", 32'(out_data), 32'(e.data));
          check_eq("out_index", 32'(out_index), 32'(e.idx));
          check_eq("out_addr", 32'(out_addr), 32'(e.addr));
          check_eq("out_last", 32'(out_last), 32'(e.idx == IDX_BITS'(TILES - 1)));
        end
        if (n_words == 0) hs_first = cyc;
        hs_last = cyc;
        n_words++;
      end
      prev_stall = out_valid & ~out_ready;
      prev_data  = out_data;
      prev_idx   = out_index;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Backpressure pattern 1,0,0,1 when enabled.
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        out_ready = (k % 4 == 0) || (k % 4 == 3);
        k++;
      end
    end
  end

  task automatic send(input logic [ADDR_BITS-1:0] addr, input logic [WORD_BITS-1:0] base);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_addr  = addr;
    in_block = make_block(base);
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #2;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("drain_timeout", 32'd0, 32'd1);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    check_eq("idle_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic wait_index(input logic [IDX_BITS-1:0] target);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (out_valid && out_index == target) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #2;
    end
    if (!ok) check_eq("wait_index_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_block  = '0;
    in_addr   = '0;
    out_ready = 1'b0;
    #12;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_out_index", 32'(out_index), 32'd0);
    check_eq("rst_out_addr", 32'(out_addr), 32'd0);
    check_eq("rst_out_last", 32'(out_last), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single block, full throughput.
    out_ready = 1'b1;
    n_words = 0;
    send(6'd5, 16'h0100);
    check_eq("t1_first_valid", 32'(out_valid), 32'd1);
    check_eq("t1_first_index", 32'(out_index), 32'd0);
    check_eq("t1_first_data", 32'(out_data), 32'h0100);
    drain();
    check_eq("t1_words", 32'(n_words), 32'd64);
    check_eq("t1_contig", 32'(hs_last - hs_first), 32'd63);
    check_eq("t1_busy", 32'(busy), 32'd0);

    // Back-to-back blocks with no gap.
    n_words = 0;
    send(6'd1, 16'hA000);
    send(6'd2, 16'hB000);
    check_eq("t2_in_ready_low", 32'(in_ready), 32'd0);
    wait_index(6'd63);
    check_eq("t2_addr_a", 32'(out_addr), 32'd1);
    @(posedge clk);
    #2;
    check_eq("t2_in_ready_high", 32'(in_ready), 32'd1);
    check_eq("t2_addr_b", 32'(out_addr), 32'd2);
    check_eq("t2_index_b", 32'(out_index), 32'd0);
    drain();
    check_eq("t2_words", 32'(n_words), 32'd128);
    check_eq("t2_contig", 32'(hs_last - hs_first), 32'd127);

    // Backpressure.
    n_words = 0;
    bp_mode = 1'b1;
    send(6'd7, 16'h3000);
    drain();
    bp_mode = 1'b0;
    check_eq("t3_words", 32'(n_words), 32'd64);

    // Full buffer: third block held until A's last word is accepted.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_words = 0;
    send(6'd10, 16'h4000);
    send(6'd11, 16'h5000);
    in_valid = 1'b1;
    in_addr  = 6'd12;
    in_block = make_block(16'h6000);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #2;
      check_eq("t4_held", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    begin
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(posedge clk);
        #2;
        if (in_ready) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) check_eq("t4_timeout", 32'd0, 32'd1);
    end
    check_eq("t4_rise_after", 32'(n_words), 32'd64);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();
    check_eq("t4_words", 32'(n_words), 32'd192);

    // Last-word accept coincides with an input handshake, P empty.
    n_words = 0;
    send(6'd20, 16'h7000);
    wait_index(6'd63);
    in_valid = 1'b1;
    in_addr  = 6'd21;
    in_block = make_block(16'h8000);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    check_eq("t5_valid", 32'(out_valid), 32'd1);
    check_eq("t5_index", 32'(out_index), 32'd0);
    check_eq("t5_addr", 32'(out_addr), 32'd21);
    check_eq("t5_data", 32'(out_data), 32'h8000);
    drain();
    check_eq("t5_words", 32'(n_words), 32'd128);
    check_eq("t5_contig", 32'(hs_last - hs_first), 32'd127);

    // Reset mid-drain with P full.
    send(6'd30, 16'h9000);
    send(6'd31, 16'hC000);
    wait_index(6'd17);
    rst = 1'b0;
    sb.delete();
    #1;
    check_eq("t6_out_valid", 32'(out_valid), 32'd0);
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_in_ready", 32'(in_ready), 32'd1);
    check_eq("t6_out_index", 32'(out_index), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    n_words = 0;
    send(6'd32, 16'hD000);
    check_eq("t6_new_index", 32'(out_index), 32'd0);
    check_eq("t6_new_addr", 32'(out_addr), 32'd32);
    drain();
    check_eq("t6_words", 32'(n_words), 32'd64);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
